// File: rtl/obstacle_pkg.sv
// Shared obstacle definitions: obstacle types, playfield and speed constants,
// and the spawner/slot state encodings.
package obstacle_pkg;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    CACTUS_SMALL = 3'd1,
    CACTUS_LARGE = 3'd2,
    PTERODACTYL  = 3'd3
  } type_t;

  localparam int GAME_WIDTH      = 640;
  localparam int SPEED_SCALE     = 1024;
  localparam int MIN_SPEED       = 6 * SPEED_SCALE;
  // Pterodactyls only appear once the horizon moves at 8.5 px/frame or faster.
  localparam int PTERO_MIN_SPEED = (17 * SPEED_SCALE) / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CRASHED = 2'd2
  } spawner_state_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    LIVE    = 2'd2
  } slot_state_t;

endpackage

// File: rtl/obstacle_spawner_if.sv
// Obstacle slot bundle between the spawner (master) and the obstacle
// instances (slave).
//   slot_start  : per-slot launch request
//   slot_typ    : per-slot obstacle type, held for the obstacle's lifetime
//   slot_remove : obstacle has left the screen
//   slot_gap    : required gap after the obstacle (unsigned)
//   slot_x_pos  : obstacle x position (signed)
//   slot_width  : obstacle width (unsigned)
interface obstacle_spawner_if #(
  parameter int SLOTS = 3
);
  logic [SLOTS-1:0]       slot_start;
  logic [SLOTS-1:0][2:0]  slot_typ;
  logic [SLOTS-1:0]       slot_remove;
  logic [SLOTS-1:0][10:0] slot_gap;
  logic [SLOTS-1:0][10:0] slot_x_pos;
  logic [SLOTS-1:0][9:0]  slot_width;

  modport master (
    output slot_start, slot_typ,
    input  slot_remove, slot_gap, slot_x_pos, slot_width
  );

  modport slave (
    input  slot_start, slot_typ,
    output slot_remove, slot_gap, slot_x_pos, slot_width
  );
endinterface

// File: rtl/obstacle_type_picker.sv
// Combinational obstacle type choice.
//   rng_data : random word, reduced mod 3 to a base type
//   speed    : horizon speed (SPEED_SCALE fixed point), gates pterodactyls
//   last_typ : type of the previous spawn
//   dup_cnt  : consecutive spawns of last_typ so far
//   typ      : chosen type
module obstacle_type_picker
  import obstacle_pkg::*;
#(
  parameter int MAX_DUP = 2,
  parameter int DUP_W   = 2
) (
  input  logic [10:0]      rng_data,
  input  logic [14:0]      speed,
  input  type_t            last_typ,
  input  logic [DUP_W-1:0] dup_cnt,
  output type_t            typ
);
  logic [1:0] r;
  type_t      base;

  always_comb begin
    r    = 2'(rng_data % 11'd3);
    base = CACTUS_SMALL;
    case (r)
      2'd1:    base = CACTUS_LARGE;
      2'd2:    base = (speed < 15'(PTERO_MIN_SPEED)) ? CACTUS_SMALL : PTERODACTYL;
      default: base = CACTUS_SMALL;
    endcase
    typ = base;
    if (base == last_typ && dup_cnt >= DUP_W'(MAX_DUP))
      typ = (base == CACTUS_SMALL) ? CACTUS_LARGE : CACTUS_SMALL;
  end
endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: owns SLOTS obstacle slots and decides, on each frame
// update, whether to launch the next obstacle and of which type.
//   clk, rst_n   : clock, asynchronous active-low reset
//   update       : one-cycle frame strobe; all state changes happen on it
//   game_start   : leaves IDLE
//   crash        : enters CRASHED (terminal until reset)
//   speed        : horizon speed, SPEED_SCALE fixed point
//   rng_data     : random word for type choice
//   slot_if      : obstacle slot bundle (master side)
//   slot_live    : slot is PENDING or LIVE
//   spawn_count  : total spawns, saturating
//   state        : spawner_state_t
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int SLOTS   = 3,
  parameter int MAX_DUP = 2,
  parameter int SLOT_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                update,
  input  logic                game_start,
  input  logic                crash,
  input  logic [14:0]         speed,
  input  logic [10:0]         rng_data,
  obstacle_spawner_if.master  slot_if,
  output logic [SLOTS-1:0]    slot_live,
  output logic [15:0]         spawn_count,
  output logic [1:0]          state
);
  localparam int DUP_W = $clog2(MAX_DUP + 2);

  spawner_state_t   state_q, state_d;
  slot_state_t      slot_q [SLOTS];
  slot_state_t      slot_d [SLOTS];
  type_t            typ_q  [SLOTS];
  type_t            typ_d  [SLOTS];
  logic [SLOTS-1:0] start_q, start_d;
  type_t            last_typ_q, last_typ_d;
  logic [DUP_W-1:0] dup_q, dup_d;
  logic [SLOT_W-1:0] last_slot_q, last_slot_d;
  logic [15:0]      count_q, count_d;

  type_t             pick;
  logic [SLOTS-1:0]  clear;
  logic              any_busy, free_found, last_clear, spawn_ok;
  logic [SLOT_W-1:0] free_idx;
  logic [12:0]       sum;

  obstacle_type_picker #(.MAX_DUP(MAX_DUP), .DUP_W(DUP_W)) u_picker (
    .rng_data (rng_data),
    .speed    (speed),
    .last_typ (last_typ_q),
    .dup_cnt  (dup_q),
    .typ      (pick)
  );

  // Spawn eligibility is judged on the current slot states only, so a slot
  // freed on this update cannot be reused until the next one.
  always_comb begin
    clear      = '0;
    any_busy   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    sum        = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      sum = {{2{slot_if.slot_x_pos[i][10]}}, slot_if.slot_x_pos[i]}
          + {3'b000, slot_if.slot_width[i]}
          + {2'b00, slot_if.slot_gap[i]};
      clear[i] = $signed(sum) < 13'sd640;
      if (slot_q[i] != FREE) any_busy = 1'b1;
      if (slot_q[i] == FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    case (slot_q[last_slot_q])
      FREE:    last_clear = 1'b1;
      LIVE:    last_clear = clear[last_slot_q];
      default: last_clear = 1'b0;
    endcase
    spawn_ok = free_found && (!any_busy || last_clear);
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    typ_d       = typ_q;
    start_d     = start_q;
    last_typ_d  = last_typ_q;
    dup_d       = dup_q;
    last_slot_d = last_slot_q;
    count_d     = count_q;
    if (update) begin
      case (state_q)
        IDLE: if (game_start) state_d = ACTIVE;
        ACTIVE: begin
          if (crash) begin
            state_d = CRASHED;
            start_d = '0;
          end else begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
              case (slot_q[i])
                PENDING: begin
                  slot_d[i]  = LIVE;
                  start_d[i] = 1'b0;
                end
                LIVE:    if (slot_if.slot_remove[i]) slot_d[i] = FREE;
                default: ;
              endcase
            end
            if (spawn_ok) begin
              slot_d[free_idx]  = PENDING;
              start_d[free_idx] = 1'b1;
              typ_d[free_idx]   = pick;
              last_slot_d       = free_idx;
              last_typ_d        = pick;
              dup_d             = (pick == last_typ_q) ? dup_q + 1'b1 : DUP_W'(1);
              if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_q[i] <= FREE;
        typ_q[i]  <= NONE;
      end
      start_q     <= '0;
      last_typ_q  <= NONE;
      dup_q       <= '0;
      last_slot_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      typ_q       <= typ_d;
      start_q     <= start_d;
      last_typ_q  <= last_typ_d;
      dup_q       <= dup_d;
      last_slot_q <= last_slot_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    slot_if.slot_start = start_q;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      slot_if.slot_typ[i] = typ_q[i];
      slot_live[i]        = (slot_q[i] != FREE);
    end
  end

  assign spawn_count = count_q;
  assign state       = state_q;

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
Initiator side of the obstacle slot interface. Owns a pool of SLOTS obstacle instances and decides when to launch the next one and which type it is. Drives each slot's start and typ; consumes each slot's remove, gap, x_pos and width. Sits in the horizon logic between the RNG/speed controller and the obstacle instances.

Parameters:
SLOTS, 3, number of obstacle instances managed (2..4)
MAX_DUP, 2, max consecutive spawns of the same type
SLOT_W, 2, index width; must satisfy 2**SLOT_W >= SLOTS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
update  in  1  one-cycle frame strobe; all decisions happen only on update cycles
game_start  in  1  sampled on update; leaves IDLE
crash  in  1  sampled on update; enters CRASHED
speed  in  15  horizon speed, SPEED_SCALE=1024 fixed point
rng_data  in  11  random word
slot_remove  in  SLOTS  per-slot remove flag from each obstacle
slot_gap  in  SLOTS x 11  per-slot gap, unsigned
slot_x_pos  in  SLOTS x 11  per-slot x position, signed
slot_width  in  SLOTS x 10  per-slot width, unsigned
slot_start  out  SLOTS  per-slot launch request, registered
slot_typ  out  SLOTS x 3  per-slot type_t, registered and held for the obstacle's lifetime
slot_live  out  SLOTS  slot is PENDING or LIVE
spawn_count  out  16  total spawns, saturating at 16'hFFFF
state  out  2  spawner_state_t

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; all slots FREE.
  - slot_start=0, slot_typ=NONE, slot_live=0, spawn_count=0.
  - last_typ=NONE, dup_cnt=0, last_slot=0.
- Non-update cycles: no register changes.
- Top FSM:
  - IDLE -> ACTIVE on update with game_start=1.
  - ACTIVE -> CRASHED on update with crash=1. Crash has priority: no spawn and no slot transition on that update.
  - CRASHED is terminal until reset.
  - In CRASHED: slot_start forced 0; slot_typ and slot_live are frozen so crashed obstacles keep rendering.
- Per-slot FSM (ACTIVE only):
  - FREE -> PENDING on spawn: slot_start[i]=1, slot_typ[i]=chosen type.
  - PENDING -> LIVE on the next update: slot_start[i]=0. The obstacle consumes the start on this same edge.
  - LIVE -> FREE on update with slot_remove[i]=1. slot_typ[i] is held until the next spawn overwrites it.
  - slot_remove is ignored in FREE and PENDING, because it is stale from the previous lifetime.
- Spawn condition (evaluated on an ACTIVE update, at most one spawn per update):
  - A FREE slot must exist.
  - Either no slot is PENDING/LIVE, or slot last_slot is LIVE and clear.
  - clear: 13-bit signed sum slot_x_pos + width + gap < 640.
  - If last_slot is FREE (already removed), treat it as clear.
  - If last_slot is PENDING, it is never clear.
  - Target slot is the lowest-index FREE slot; last_slot takes that index.
  - A slot freed on the same update is not eligible until the next update.
- Latency:
  - Spawn decision at update N; slot_start visible from the cycle after N until update N+1.
  - The first spawn happens on the first ACTIVE update after entering ACTIVE.
- Type choice:
  - r = rng_data % 3, mapped 0=CACTUS_SMALL, 1=CACTUS_LARGE, 2=PTERODACTYL.
  - If PTERODACTYL and speed < 8704, use CACTUS_SMALL.
  - Then, if choice == last_typ and dup_cnt >= MAX_DUP: SMALL becomes LARGE; any other type becomes SMALL.
  - On spawn: dup_cnt = (choice==last_typ) ? dup_cnt+1 : 1; last_typ = choice.

Decomposition:
- Reuse obstacle_pkg::type_t, GAME_WIDTH, SPEED_SCALE and MIN_SPEED.
- Add to obstacle_pkg:
  - spawner_state_t {IDLE, ACTIVE, CRASHED}
  - slot_state_t {FREE, PENDING, LIVE}
  - PTERO_MIN_SPEED
- One sub-module, obstacle_type_picker: combinational type choice from rng_data, speed, last_typ, dup_cnt. Keep it separate so it can be tested in isolation.

Test Plan:
- Reset mid-ACTIVE with slot0 LIVE -> all outputs return to reset values immediately, without waiting for clk.
- game_start, then update with rng_data=0 -> slot_start=001, slot_typ[0]=CACTUS_SMALL; next update -> slot_start=000, slot_live=001, spawn_count=1.
- slot0 LIVE with x=500, width=17, gap=140 (sum 657) -> no spawn; x drops to 480 (sum 637) -> slot1 spawns on that update.
- rng_data=2, speed=8000 -> CACTUS_SMALL; same with speed=9000 -> PTERODACTYL.
- Three consecutive spawns with rng_data=1, MAX_DUP=2 -> LARGE, LARGE, SMALL.
- All 3 slots LIVE and clear -> no spawn; slot1 remove -> slot1 FREE that update, spawn into slot1 next update; crash on the same update as a spawn-eligible condition -> CRASHED, no spawn, slot_typ unchanged.
